memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
- REQ-001 Parameter TIMEOUT_CYC, default 255, meaning: wait-cycle limit before abort; valid range 1..255; used only with MEM_TIMEOUT_EN.
- REQ-002 clk  input  1  single clock; all state changes on its rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 Result  input  32  execute-stage result: ALU value or store data.
- REQ-005 Addr  input  32  execute-stage effective address.
- REQ-006 RdEnable  input  1  instruction writes a register.
- REQ-007 AddrEnable  input  1  instruction accesses memory.
- REQ-008 LdEnable  input  1  memory access is a load (1) or a store (0).
- REQ-009 RdIdx  input  5  destination register index.
- REQ-010 Flush_in  input  1  squash the instruction presented this cycle.
- REQ-011 MemReq  output  1  memory request, held until acknowledged.
- REQ-012 MemWe  output  1  store strobe, qualified by MemReq.
- REQ-013 MemAddr  output  32  word address: {Addr[31:2],2'b00}.
- REQ-014 MemWData  output  32  store data.
- REQ-015 MemRData  input  32  load data, valid with MemAck.
- REQ-016 MemAck  input  1  one-cycle request completion.
- REQ-017 WbData  output  32  writeback value.
- REQ-018 WbIdx  output  5  writeback register index.
- REQ-019 WbEnable  output  1  one-cycle writeback strobe.
- REQ-020 Stall  output  1  upstream holds its outputs while high.
- REQ-021 MemErr  output  1  one-cycle timeout-abort pulse; tied 0 without MEM_TIMEOUT_EN.

Function
- REQ-022 The block SHALL run a two-state FSM: IDLE and WAIT.
- REQ-023 Capture: in IDLE with rst=0, the block SHALL register Result, Addr, RdIdx, LdEnable, RdEnable and AddrEnable every cycle.
- REQ-024 When Flush_in=1 at capture, the captured instruction SHALL be treated as a no-op: no request and no writeback.
- REQ-025 ALU op (AddrEnable=0, RdEnable=1): WbEnable=1, WbData=Result, WbIdx=RdIdx exactly one cycle after capture; the FSM stays in IDLE.
- REQ-026 No-op (AddrEnable=0, RdEnable=0): no output activity.
- REQ-027 Memory op (AddrEnable=1): the FSM SHALL go to WAIT.
  - MemReq=1 from the cycle after capture.
  - MemWe=~LdEnable.
  - MemAddr and MemWData=Result SHALL stay stable until the ack.
- REQ-028 Stall SHALL equal (state==WAIT), combinationally; no capture occurs while Stall=1.
- REQ-029 In WAIT with MemAck=1, the block SHALL drop MemReq the next cycle and return to IDLE.
  - Load with RdEnable=1: WbEnable=1, WbData=MemRData and the captured RdIdx in that next cycle.
  - Load with RdEnable=0: the data SHALL be discarded.
- REQ-030 A store SHALL never assert WbEnable.
- REQ-031 MemAck in IDLE SHALL be ignored.
- REQ-032 Flush_in in WAIT SHALL NOT abort the outstanding access.
- REQ-033 An address with Addr[1:0]!=0 SHALL be silently word-aligned.
- REQ-034 WbEnable SHALL never be high for two consecutive cycles from one instruction.
- REQ-035 The first capture in IDLE after a completed access SHALL occur in the cycle Stall falls.

Reset
- REQ-036 With rst=1 at a clock edge, the block SHALL set: state=IDLE, MemReq=0, MemWe=0, WbEnable=0, MemErr=0, MemAddr=0, MemWData=0, WbData=0, WbIdx=0, timeout counter=0.
- REQ-037 Reset asserted in WAIT SHALL abandon the access with no writeback; a later MemAck SHALL be ignored.

Configuration
- REQ-038 With macro MEM_TIMEOUT_EN defined, an 8-bit counter SHALL run as follows.
  - It clears on entry to WAIT and increments each WAIT cycle without MemAck.
  - When it reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, drop MemReq and pulse MemErr for one cycle, with no writeback.
  - MemAck in the same cycle as the limit SHALL take priority and complete normally.
- REQ-039 With MEM_TIMEOUT_EN undefined, the block SHALL have no counter, WAIT SHALL last until MemAck, and MemErr SHALL be constant 0.

Verification
- REQ-040 ALU: Result=0x0000_1234, RdIdx=5, RdEnable=1, AddrEnable=0 -> next cycle WbEnable=1, WbData=0x0000_1234, WbIdx=5, Stall=0, MemReq=0.
- REQ-041 Load: Addr=0x0000_0103, LdEnable=1, RdEnable=1, RdIdx=7; MemAck=1 with MemRData=0xDEAD_BEEF on the third WAIT cycle -> MemAddr=0x0000_0100, MemWe=0, Stall=1 for 3 cycles, then WbData=0xDEAD_BEEF to WbIdx=7 one cycle after the ack.
- REQ-042 Store: Addr=0x40, Result=0xA5A5_A5A5, LdEnable=0, RdEnable=0; ack after 1 cycle -> MemWe=1, MemWData=0xA5A5_A5A5, WbEnable never 1.
- REQ-043 Flush: load presented with Flush_in=1 -> MemReq stays 0, WbEnable stays 0; Flush_in=1 during WAIT -> access completes normally.
- REQ-044 Reset in WAIT: rst=1 on the second WAIT cycle, then MemAck -> MemReq=0, Stall=0, no WbEnable.
- REQ-045 MEM_TIMEOUT_EN defined, TIMEOUT_CYC=4, no ack -> MemErr pulses once 4 WAIT cycles after MemReq rises, then IDLE, no writeback.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: ALU writeback pass-through and single-outstanding load/store.
// Optional MEM_TIMEOUT_EN macro adds a wait-cycle abort counter limited by TIMEOUT_CYC.
module memory_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Result,
    input  logic [31:0] Addr,
    input  logic        RdEnable,
    input  logic        AddrEnable,
    input  logic        LdEnable,
    input  logic [4:0]  RdIdx,
    input  logic        Flush_in,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic [31:0] WbData,
    output logic [4:0]  WbIdx,
    output logic        WbEnable,
    output logic        Stall,
    output logic        MemErr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

    state_t state, state_nxt;

    logic       cap_ld;
    logic       cap_rd;
    logic [4:0] cap_idx;

    logic        go_mem;
    logic        go_alu;
    logic        timeout;

    logic        n_req;
    logic        n_we;
    logic [31:0] n_addr;
    logic [31:0] n_wdata;
    logic [31:0] n_wbdata;
    logic [4:0]  n_wbidx;
    logic        n_wben;

    // A flushed instruction is captured but can neither request nor write back.
    assign go_mem = AddrEnable & ~Flush_in;
    assign go_alu = ~AddrEnable & RdEnable & ~Flush_in;
    assign Stall  = (state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt + 8'd1;
    assign timeout = (state == S_WAIT) & ~MemAck & (cnt_inc == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (state == S_IDLE) begin
            cnt <= 8'd0;
        end else if (!MemAck) begin
            cnt <= cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MemErr <= 1'b0;
        end else begin
            MemErr <= timeout;
        end
    end
`else
    logic unused_limit;

    assign unused_limit = ^LIMIT;
    assign timeout      = 1'b0;
    assign MemErr       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (go_mem) state_nxt = S_WAIT;
            S_WAIT: if (MemAck || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        n_req    = MemReq;
        n_we     = MemWe;
        n_addr   = MemAddr;
        n_wdata  = MemWData;
        n_wbdata = WbData;
        n_wbidx  = WbIdx;
        n_wben   = 1'b0;
        unique case (state)
            S_IDLE: begin
                n_req   = go_mem;
                n_we    = go_mem & ~LdEnable;
                n_addr  = {Addr[31:2], 2'b00};
                n_wdata = Result;
                if (go_alu) begin
                    n_wben   = 1'b1;
                    n_wbdata = Result;
                    n_wbidx  = RdIdx;
                end
            end
            S_WAIT: begin
                if (MemAck) begin
                    n_req = 1'b0;
                    n_we  = 1'b0;
                    if (cap_ld && cap_rd) begin
                        n_wben   = 1'b1;
                        n_wbdata = MemRData;
                        n_wbidx  = cap_idx;
                    end
                end else if (timeout) begin
                    n_req = 1'b0;
                    n_we  = 1'b0;
                end
            end
            default: begin
                n_req = 1'b0;
                n_we  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= 32'd0;
            MemWData <= 32'd0;
            WbData   <= 32'd0;
            WbIdx    <= 5'd0;
            WbEnable <= 1'b0;
            cap_ld   <= 1'b0;
            cap_rd   <= 1'b0;
            cap_idx  <= 5'd0;
        end else begin
            MemReq   <= n_req;
            MemWe    <= n_we;
            MemAddr  <= n_addr;
            MemWData <= n_wdata;
            WbData   <= n_wbdata;
            WbIdx    <= n_wbidx;
            WbEnable <= n_wben;
            if (state == S_IDLE) begin
                cap_ld  <= LdEnable;
                cap_rd  <= RdEnable;
                cap_idx <= RdIdx;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU, load, store, flush, reset-in-wait
// and, when MEM_TIMEOUT_EN is defined, the timeout abort.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Result;
    logic [31:0] Addr;
    logic        RdEnable;
    logic        AddrEnable;
    logic        LdEnable;
    logic [4:0]  RdIdx;
    logic        Flush_in;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic [31:0] WbData;
    logic [4:0]  WbIdx;
    logic        WbEnable;
    logic        Stall;
    logic        MemErr;

    int total = 0;
    int bad   = 0;

    memory_access #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .Result(Result), .Addr(Addr),
        .RdEnable(RdEnable), .AddrEnable(AddrEnable),
        .LdEnable(LdEnable), .RdIdx(RdIdx),
        .Flush_in(Flush_in),
        .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck),
        .WbData(WbData), .WbIdx(WbIdx),
        .WbEnable(WbEnable), .Stall(Stall),
        .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        Result = 32'd0; Addr = 32'd0;
        RdEnable = 1'b0; AddrEnable = 1'b0;
        LdEnable = 1'b0; RdIdx = 5'd0;
    endtask

    task automatic load(input logic [31:0] a, input logic [4:0] idx);
        Result = 32'h0BAD_0BAD; Addr = a;
        RdEnable = 1'b1; AddrEnable = 1'b1;
        LdEnable = 1'b1; RdIdx = idx;
    endtask

    initial begin
        rst = 1'b1; nop(); Flush_in = 1'b0;
        MemAck = 1'b0; MemRData = 32'd0;
        tick(); tick();
        chk("rst_req", {31'd0, MemReq}, 32'd0);
        chk("rst_we", {31'd0, MemWe}, 32'd0);
        chk("rst_wben", {31'd0, WbEnable}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_wbdata", WbData, 32'd0);
        chk("rst_wbidx", {27'd0, WbIdx}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_err", {31'd0, MemErr}, 32'd0);
        rst = 1'b0;

        // ALU op
        Result = 32'h0000_1234; RdIdx = 5'd5; RdEnable = 1'b1;
        tick();
        chk("alu_wben", {31'd0, WbEnable}, 32'd1);
        chk("alu_wbdata", WbData, 32'h0000_1234);
        chk("alu_wbidx", {27'd0, WbIdx}, 32'd5);
        chk("alu_stall", {31'd0, Stall}, 32'd0);
        chk("alu_req", {31'd0, MemReq}, 32'd0);
        nop();
        tick();
        chk("alu_wben_once", {31'd0, WbEnable}, 32'd0);

        // Load, unaligned address, ack on third wait cycle
        load(32'h0000_0103, 5'd7);
        tick();
        chk("ld_req", {31'd0, MemReq}, 32'd1);
        chk("ld_we", {31'd0, MemWe}, 32'd0);
        chk("ld_addr", MemAddr, 32'h0000_0100);
        chk("ld_stall1", {31'd0, Stall}, 32'd1);
        nop();
        Result = 32'h0000_0999; RdEnable = 1'b1; RdIdx = 5'd30;
        tick();
        chk("ld_stall2", {31'd0, Stall}, 32'd1);
        chk("ld_addr_hold", MemAddr, 32'h0000_0100);
        chk("ld_no_wb_wait", {31'd0, WbEnable}, 32'd0);
        tick();
        chk("ld_stall3", {31'd0, Stall}, 32'd1);
        nop();
        MemAck = 1'b1; MemRData = 32'hDEAD_BEEF;
        tick();
        MemAck = 1'b0; MemRData = 32'd0;
        chk("ld_stall_fall", {31'd0, Stall}, 32'd0);
        chk("ld_req_drop", {31'd0, MemReq}, 32'd0);
        chk("ld_wben", {31'd0, WbEnable}, 32'd1);
        chk("ld_wbdata", WbData, 32'hDEAD_BEEF);
        chk("ld_wbidx", {27'd0, WbIdx}, 32'd7);

        // Stray ack in IDLE
        MemAck = 1'b1; MemRData = 32'h1111_1111;
        tick();
        MemAck = 1'b0;
        chk("idle_ack_wben", {31'd0, WbEnable}, 32'd0);
        chk("idle_ack_stall", {31'd0, Stall}, 32'd0);
        chk("idle_ack_req", {31'd0, MemReq}, 32'd0);

        // Store, ack after one cycle
        Addr = 32'h0000_0040; Result = 32'hA5A5_A5A5;
        AddrEnable = 1'b1; LdEnable = 1'b0; RdEnable = 1'b0; RdIdx = 5'd4;
        tick();
        chk("st_req", {31'd0, MemReq}, 32'd1);
        chk("st_we", {31'd0, MemWe}, 32'd1);
        chk("st_wdata", MemWData, 32'hA5A5_A5A5);
        chk("st_addr", MemAddr, 32'h0000_0040);
        chk("st_stall", {31'd0, Stall}, 32'd1);
        chk("st_wben_wait", {31'd0, WbEnable}, 32'd0);
        nop();
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("st_req_drop", {31'd0, MemReq}, 32'd0);
        chk("st_wben", {31'd0, WbEnable}, 32'd0);
        chk("st_stall_fall", {31'd0, Stall}, 32'd0);

        // Flushed load
        load(32'h0000_0080, 5'd8);
        Flush_in = 1'b1;
        tick();
        Flush_in = 1'b0;
        nop();
        chk("fl_req", {31'd0, MemReq}, 32'd0);
        chk("fl_stall", {31'd0, Stall}, 32'd0);
        chk("fl_wben", {31'd0, WbEnable}, 32'd0);
        tick();
        chk("fl_req2", {31'd0, MemReq}, 32'd0);
        chk("fl_wben2", {31'd0, WbEnable}, 32'd0);

        // Flush during WAIT does not abort
        load(32'h0000_0200, 5'd9);
        tick();
        chk("fw_req", {31'd0, MemReq}, 32'd1);
        nop();
        Flush_in = 1'b1;
        tick();
        chk("fw_req_hold", {31'd0, MemReq}, 32'd1);
        chk("fw_stall", {31'd0, Stall}, 32'd1);
        MemAck = 1'b1; MemRData = 32'h1234_5678;
        tick();
        MemAck = 1'b0; Flush_in = 1'b0;
        chk("fw_wben", {31'd0, WbEnable}, 32'd1);
        chk("fw_wbdata", WbData, 32'h1234_5678);
        chk("fw_wbidx", {27'd0, WbIdx}, 32'd9);

        // Reset on the second WAIT cycle, then a late ack
        load(32'h0000_0300, 5'd3);
        tick();
        nop();
        tick();
        chk("rw_stall_pre", {31'd0, Stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_req", {31'd0, MemReq}, 32'd0);
        chk("rw_stall", {31'd0, Stall}, 32'd0);
        chk("rw_wben", {31'd0, WbEnable}, 32'd0);
        MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
        tick();
        MemAck = 1'b0;
        chk("rw_late_wben", {31'd0, WbEnable}, 32'd0);
        chk("rw_late_stall", {31'd0, Stall}, 32'd0);
        chk("rw_late_req", {31'd0, MemReq}, 32'd0);

        // Wait without ack for four cycles
        load(32'h0000_0010, 5'd2);
        tick();
        nop();
        chk("to_req", {31'd0, MemReq}, 32'd1);
        chk("to_err1", {31'd0, MemErr}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("to_err_wait", {31'd0, MemErr}, 32'd0);
            chk("to_stall_wait", {31'd0, Stall}, 32'd1);
        end
        tick();
`ifdef MEM_TIMEOUT_EN
        chk("to_err_pulse", {31'd0, MemErr}, 32'd1);
        chk("to_stall_off", {31'd0, Stall}, 32'd0);
        chk("to_req_off", {31'd0, MemReq}, 32'd0);
        chk("to_wben", {31'd0, WbEnable}, 32'd0);
        tick();
        chk("to_err_once", {31'd0, MemErr}, 32'd0);
        chk("to_wben2", {31'd0, WbEnable}, 32'd0);
`else
        chk("nto_err", {31'd0, MemErr}, 32'd0);
        chk("nto_stall", {31'd0, Stall}, 32'd1);
        chk("nto_req", {31'd0, MemReq}, 32'd1);
        MemAck = 1'b1; MemRData = 32'h0000_00AB;
        tick();
        MemAck = 1'b0;
        chk("nto_wben", {31'd0, WbEnable}, 32'd1);
        chk("nto_wbdata", WbData, 32'h0000_00AB);
        chk("nto_stall_off", {31'd0, Stall}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
